wb_write_queue: RTL and testbench

- Write-back buffer that collects register-write requests from two producers, the ALU result path and the load-return path.
- Buffers the requests in order and drains them, one per cycle, into the 32x32 register file write port (we3/wa3/wd3).
- Provides a two-port bypass lookup so operand reads can see values that are queued but not yet written.
- Sits between the execute/memory stages and the register file.

---
 rtl/wb_write_queue.sv | 117 +++++++++++
 tb/tb_wb_write_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// In-order write-back queue: merges ALU and load-return register writes and
// drains them one per cycle into the register file, with a two-port bypass lookup.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,

    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,

    input  logic          drain_en,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,

    input  logic [AW-1:0] qa1,
    input  logic [AW-1:0] qa2,
    output logic          qhit1,
    output logic          qhit2,
    output logic [DW-1:0] qd1,
    output logic [DW-1:0] qd2,

    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic          ld_acc;
    logic          alu_acc;
    logic          push;
    logic          pop;
    logic [AW-1:0] enq_addr;
    logic [DW-1:0] enq_data;

    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Load returns win arbitration; readiness looks only at registered count.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;

    assign ld_acc   = ld_valid && ld_ready;
    assign alu_acc  = alu_valid && alu_ready;
    assign enq_addr = ld_acc ? ld_addr : alu_addr;
    assign enq_data = ld_acc ? ld_data : alu_data;

    // Writes to r0 are swallowed: the handshake completes but nothing is stored.
    assign push = (ld_acc || alu_acc) && (enq_addr != '0);

    assign we3 = !empty && drain_en;
    assign pop = we3;
    assign wa3 = we3 ? mem_addr[rd_ptr] : '0;
    assign wd3 = we3 ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= enq_addr;
            mem_data[wr_ptr] <= enq_data;
        end
    end

    // Walk oldest to youngest so the last match leaves the youngest data.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] qa);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < cnt) && (qa != '0) && (mem_addr[idx] == qa)) begin
                res = {1'b1, mem_data[idx]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {qhit1, qd1} = lookup(qa1);
        {qhit2, qd2} = lookup(qa2);
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, ld_valid, drain_en;
    logic          alu_ready, ld_ready;
    logic [AW-1:0] alu_addr, ld_addr, qa1, qa2, wa3;
    logic [DW-1:0] alu_data, ld_data, wd3, qd1, qd2;
    logic          we3, qhit1, qhit2, full, empty;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .drain_en(drain_en), .we3(we3), .wa3(wa3), .wd3(wd3),
        .qa1(qa1), .qa2(qa2), .qhit1(qhit1), .qhit2(qhit2), .qd1(qd1), .qd2(qd2),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_query(input logic [AW-1:0] qa, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) begin
            if (qa != 0 && mq[i].a == qa) begin
                hit = 1'b1;
                d   = mq[i].d;
            end
        end
    endtask

    task automatic check_outputs();
        int            n;
        logic          h;
        logic [DW-1:0] d;
        logic          we_e;
        n    = mq.size();
        we_e = (n > 0) && drain_en;
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("ld_ready", 32'(ld_ready), 32'(n != DEPTH));
        chk("alu_ready", 32'(alu_ready), 32'((n != DEPTH) && !ld_valid));
        chk("we3", 32'(we3), 32'(we_e));
        chk("wa3", 32'(wa3), we_e ? 32'(mq[0].a) : 32'h0);
        chk("wd3", wd3, we_e ? mq[0].d : 32'h0);
        model_query(qa1, h, d);
        chk("qhit1", 32'(qhit1), 32'(h));
        chk("qd1", qd1, d);
        model_query(qa2, h, d);
        chk("qhit2", 32'(qhit2), 32'(h));
        chk("qd2", qd2, d);
    endtask

    // One clock: check the settled outputs, then advance the model over the edge.
    task automatic cycle();
        int   n;
        ent_t e;
        #1;
        check_outputs();
        n = mq.size();
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            e.a = '0;
            e.d = '0;
            if (ld_valid && n < DEPTH) begin
                e.a = ld_addr;
                e.d = ld_data;
            end else if (alu_valid && !ld_valid && n < DEPTH) begin
                e.a = alu_addr;
                e.d = alu_data;
            end
            if (drain_en && n > 0) void'(mq.pop_front());
            if (e.a != 0) mq.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        mq.delete();
        chk("rst_we3", 32'(we3), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        check_outputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; ld_valid = 0;
        alu_addr = 0; alu_data = 0; ld_addr = 0; ld_data = 0;
    endtask

    task automatic alu_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        alu_valid = 1; alu_addr = a; alu_data = d;
        cycle();
        alu_valid = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        drain_en = 0; qa1 = 0; qa2 = 0;
        do_reset();

        // Single ALU write flows straight through.
        drain_en = 1;
        alu_req(5'd5, 32'hDEADBEEF);
        #1;
        chk("t1_we3", 32'(we3), 32'h1);
        chk("t1_wa3", 32'(wa3), 32'h5);
        chk("t1_wd3", wd3, 32'hDEADBEEF);
        cycle();
        chk("t1_empty", 32'(empty), 32'h1);
        cycle();

        // Simultaneous requests: load first, ALU held off.
        ld_valid = 1; ld_addr = 3; ld_data = 32'h33;
        alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
        #1;
        chk("t2_alu_ready", 32'(alu_ready), 32'h0);
        cycle();
        ld_valid = 0;
        cycle();
        alu_valid = 0;
        repeat (3) cycle();

        // Fill with drain disabled, then drain back-to-back.
        drain_en = 0;
        for (int i = 1; i <= 4; i++) alu_req(AW'(i), 32'h100 + i);
        alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
        #1;
        chk("t3_full", 32'(full), 32'h1);
        chk("t3_count", 32'(count), 32'h4);
        chk("t3_alu_ready", 32'(alu_ready), 32'h0);
        chk("t3_ld_ready", 32'(ld_ready), 32'h0);
        cycle();
        alu_valid = 0;
        drain_en = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t3_drain_wa3", 32'(wa3), 32'(i));
            cycle();
        end
        cycle();

        // Bypass picks the youngest of two same-register entries.
        drain_en = 0;
        alu_req(5'd7, 32'h11);
        alu_req(5'd7, 32'h22);
        qa1 = 7; qa2 = 0;
        #1;
        chk("t4_qhit1", 32'(qhit1), 32'h1);
        chk("t4_qd1", qd1, 32'h22);
        chk("t4_qhit2", 32'(qhit2), 32'h0);
        chk("t4_qd2", qd2, 32'h0);
        cycle();
        drain_en = 1;
        repeat (3) cycle();

        // r0 writes are accepted but never stored.
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
        #1;
        chk("t5_alu_ready", 32'(alu_ready), 32'h1);
        cycle();
        alu_valid = 0;
        chk("t5_count", 32'(count), 32'h0);
        repeat (2) cycle();

        // Reset asserted mid-drain discards the rest.
        drain_en = 0;
        for (int i = 0; i < 3; i++) alu_req(AW'(10 + i), 32'hA0 + i);
        drain_en = 1;
        cycle();
        do_reset();
        repeat (4) cycle();

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            ld_valid  = ($urandom_range(3) == 0);
            alu_valid = ($urandom_range(1) == 0);
            ld_addr   = AW'($urandom_range(7));
            alu_addr  = AW'($urandom_range(7));
            ld_data   = $urandom;
            alu_data  = $urandom;
            drain_en  = ($urandom_range(9) < 6);
            qa1       = AW'($urandom_range(7));
            qa2       = AW'($urandom_range(7));
            if ($urandom_range(99) == 0) do_reset();
            else cycle();
        end
        idle_inputs();
        drain_en = 1;
        repeat (DEPTH + 2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
